square_motion_sequencer: RTL

- Synchronous replacement for the per-frame square motion update.
- Once per frame it walks N_SQ squares through one shared axis-step datapath: X then Y per square, with bounce and clamp.
- Results are held in working registers and published to the renderer in one atomic commit.
- Sits between the hvsync generator's frame-start pulse and the colour compare logic; runs entirely on clk, with no logic clocked by vsync.

---
 rtl/sq_motion_pkg.sv | 27 ++
 rtl/square_axis_step.sv | 45 ++++
 rtl/square_motion_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sq_motion_pkg.sv
// Shared types and reset formulas for the square motion sequencer.
// Coordinates are 10-bit unsigned; step arithmetic uses one extra bit.
package sq_motion_pkg;

  localparam int COORD_W = 10;
  localparam int CALC_W  = COORD_W + 1;
  localparam int SIZE_W  = 8;

  // Every square starts moving down; X direction alternates by square index.
  localparam logic DIR_Y_RESET = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_X  = 2'd1,
    UPD_Y  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic [COORD_W-1:0] reset_pos(input int i, input int spacing);
    return COORD_W'(i * spacing);
  endfunction

  function automatic logic reset_dir_x(input int i);
    return ~i[0];
  endfunction

endpackage

// File: rtl/square_axis_step.sv
// One axis of square motion: advance, bounce at the far edge, clamp at zero.
// Purely combinational; the sequencer shares one instance between X and Y.
module square_axis_step
  import sq_motion_pkg::*;
(
  input  logic [COORD_W-1:0] pos,
  input  logic               dir,
  input  logic [COORD_W-1:0] step,
  input  logic [COORD_W-1:0] limit,
  input  logic [SIZE_W-1:0]  size,
  output logic [COORD_W-1:0] next_pos,
  output logic               next_dir
);

  logic [CALC_W-1:0] lim;
  logic [CALC_W-1:0] sum;

  always_comb begin
    // A square larger than the screen collapses the travel range to zero.
    if (CALC_W'(size) > CALC_W'(limit)) begin
      lim = '0;
    end else begin
      lim = CALC_W'(limit) - CALC_W'(size);
    end
    sum      = CALC_W'(pos) + CALC_W'(step);
    next_pos = pos;
    next_dir = dir;
    if (dir) begin
      if (sum >= lim) begin
        next_pos = lim[COORD_W-1:0];
        next_dir = 1'b0;
      end else begin
        next_pos = sum[COORD_W-1:0];
      end
    end else begin
      if (pos <= step) begin
        next_pos = '0;
        next_dir = 1'b1;
      end else begin
        next_pos = pos - step;
      end
    end
  end

endmodule

// File: rtl/square_motion_sequencer.sv
// Per-frame square motion update: sweeps X then Y for each square through one
// shared axis stepper, then publishes all positions to the renderer at once.
module square_motion_sequencer
  import sq_motion_pkg::*;
#(
  parameter int N_SQ      = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int X_STEP    = 7,
  parameter int Y_STEP    = 6,
  parameter int X_SPACING = 120,
  parameter int Y_SPACING = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    run,
  input  logic [SIZE_W-1:0]       size,
  output logic                    busy,
  output logic                    upd_done,
  output logic                    overrun,
  output logic [N_SQ*COORD_W-1:0] pos_x,
  output logic [N_SQ*COORD_W-1:0] pos_y
);

  localparam int IDX_W = $clog2(N_SQ);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [SIZE_W-1:0]   size_q;

  logic [COORD_W-1:0]  work_x [N_SQ];
  logic [COORD_W-1:0]  work_y [N_SQ];
  logic [N_SQ-1:0]     dir_x;
  logic [N_SQ-1:0]     dir_y;
  logic [COORD_W-1:0]  pub_x  [N_SQ];
  logic [COORD_W-1:0]  pub_y  [N_SQ];

  logic                start, step_x, step_y, commit;
  logic [COORD_W-1:0]  axis_pos, axis_step, axis_limit, axis_next_pos;
  logic                axis_dir, axis_next_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    start      = 1'b0;
    step_x     = 1'b0;
    step_y     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_tick && run) begin
          start      = 1'b1;
          idx_next   = '0;
          state_next = UPD_X;
        end
      end
      UPD_X: begin
        step_x     = 1'b1;
        state_next = UPD_Y;
      end
      UPD_Y: begin
        step_y = 1'b1;
        if (idx_reg == IDX_W'(N_SQ - 1)) begin
          state_next = COMMIT;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = UPD_X;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  // Shared stepper: operands selected by which axis the FSM is on.
  always_comb begin
    if (step_y) begin
      axis_pos   = work_y[idx_reg];
      axis_dir   = dir_y[idx_reg];
      axis_step  = COORD_W'(Y_STEP) + COORD_W'(idx_reg);
      axis_limit = COORD_W'(V_RES);
    end else begin
      axis_pos   = work_x[idx_reg];
      axis_dir   = dir_x[idx_reg];
      axis_step  = COORD_W'(X_STEP) + COORD_W'(idx_reg);
      axis_limit = COORD_W'(H_RES);
    end
  end

  square_axis_step u_axis_step (
    .pos      (axis_pos),
    .dir      (axis_dir),
    .step     (axis_step),
    .limit    (axis_limit),
    .size     (size_q),
    .next_pos (axis_next_pos),
    .next_dir (axis_next_dir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q   <= '0;
      upd_done <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < N_SQ; i++) begin
        work_x[i] <= reset_pos(i, X_SPACING);
        work_y[i] <= reset_pos(i, Y_SPACING);
        pub_x[i]  <= reset_pos(i, X_SPACING);
        pub_y[i]  <= reset_pos(i, Y_SPACING);
        dir_x[i]  <= reset_dir_x(i);
        dir_y[i]  <= DIR_Y_RESET;
      end
    end else begin
      upd_done <= commit;
      // A tick landing mid-sweep is dropped but reported.
      overrun  <= frame_tick && busy;
      if (start) begin
        size_q <= size;
      end
      if (step_x) begin
        work_x[idx_reg] <= axis_next_pos;
        dir_x[idx_reg]  <= axis_next_dir;
      end
      if (step_y) begin
        work_y[idx_reg] <= axis_next_pos;
        dir_y[idx_reg]  <= axis_next_dir;
      end
      if (commit) begin
        for (int i = 0; i < N_SQ; i++) begin
          pub_x[i] <= work_x[i];
          pub_y[i] <= work_y[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_SQ; gi++) begin : g_pack
    assign pos_x[gi*COORD_W +: COORD_W] = pub_x[gi];
    assign pos_y[gi*COORD_W +: COORD_W] = pub_y[gi];
  end

endmodule
